// File: rtl/asg_seg_sequencer_if.sv
// Bus between the ASG register bank (master) and the segment sequencer (slave),
// carrying table config, sequence control and the reprogramming outputs for one channel.
interface asg_seg_sequencer_if #(
    parameter int RSZ  = 14,
    parameter int NSEG = 8
);
    localparam int SW = $clog2(NSEG);

    logic              cfg_we_i;
    logic [SW+2:0]     cfg_addr_i;
    logic [31:0]       cfg_wdata_i;
    logic [31:0]       cfg_rdata_o;
    logic              start_i;
    logic              stop_i;
    logic [SW:0]       nseg_i;
    logic              loop_i;
    logic              busy_o;
    logic [SW-1:0]     seg_o;
    logic              done_o;
    logic [RSZ+15:0]   set_step_o;
    logic [RSZ+15:0]   set_ofs_o;
    logic [RSZ+15:0]   set_size_o;
    logic [15:0]       set_ncyc_o;
    logic              set_rst_o;
    logic              trig_sw_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_wdata_i, start_i, stop_i, nseg_i, loop_i,
        input  cfg_rdata_o, busy_o, seg_o, done_o,
        input  set_step_o, set_ofs_o, set_size_o, set_ncyc_o, set_rst_o, trig_sw_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i, start_i, stop_i, nseg_i, loop_i,
        output cfg_rdata_o, busy_o, seg_o, done_o,
        output set_step_o, set_ofs_o, set_size_o, set_ncyc_o, set_rst_o, trig_sw_o
    );
endinterface

// File: rtl/asg_seg_sequencer.sv
// Segment sequencer for one ASG channel: replays a table of {step, ofs, size, ncyc, dwell} segments.
// Latency: LOAD one cycle after start, software trigger the next, then max(dwell,1) RUN cycles; readback 1 cycle.
// No backpressure: the channel is always ready; stop aborts to IDLE from any state and wins over start.
module asg_seg_sequencer #(
    parameter int RSZ  = 14,
    parameter int NSEG = 8
) (
    input  logic dac_clk_i,
    input  logic dac_rst_i,
    asg_seg_sequencer_if.slave bus
);
    localparam int SW = $clog2(NSEG);
    localparam int CW = RSZ + 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_TRIG = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam logic [SW:0] NSEG_ONE = (SW+1)'(1);
    localparam logic [SW:0] NSEG_MAX = (SW+1)'(NSEG);

    typedef struct packed {
        logic [CW-1:0] step;
        logic [CW-1:0] ofs;
        logic [CW-1:0] size;
        logic [15:0]   ncyc;
        logic [31:0]   dwell;
    } seg_t;

    seg_t tbl_q [NSEG];

    logic [SW-1:0] cfg_seg;
    logic [2:0]    cfg_fld;
    assign {cfg_seg, cfg_fld} = bus.cfg_addr_i;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            for (int i = 0; i < NSEG; i++) tbl_q[i] <= '0;
        end else if (bus.cfg_we_i) begin
            case (cfg_fld)
                3'd0:    tbl_q[cfg_seg].step  <= bus.cfg_wdata_i[CW-1:0];
                3'd1:    tbl_q[cfg_seg].ofs   <= bus.cfg_wdata_i[CW-1:0];
                3'd2:    tbl_q[cfg_seg].size  <= bus.cfg_wdata_i[CW-1:0];
                3'd3:    tbl_q[cfg_seg].ncyc  <= bus.cfg_wdata_i[15:0];
                3'd4:    tbl_q[cfg_seg].dwell <= bus.cfg_wdata_i;
                default: ;
            endcase
        end
    end

    seg_t        rd_ent;
    logic [31:0] rd_d;
    logic [31:0] cfg_rdata_q;

    always_comb begin
        rd_ent = tbl_q[cfg_seg];
        rd_d   = '0;
        case (cfg_fld)
            3'd0:    rd_d = 32'(rd_ent.step);
            3'd1:    rd_d = 32'(rd_ent.ofs);
            3'd2:    rd_d = 32'(rd_ent.size);
            3'd3:    rd_d = 32'(rd_ent.ncyc);
            3'd4:    rd_d = rd_ent.dwell;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) cfg_rdata_q <= '0;
        else           cfg_rdata_q <= rd_d;
    end

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [SW:0]   nseg_q, nseg_clamp;
    logic [31:0]   dwell_q, seg_dwell_q;
    logic          done_d, run_end, last_seg;

    assign run_end  = (state_q == ST_RUN) && (dwell_q == 32'd1);
    assign last_seg = ({1'b0, seg_q} >= (nseg_q - NSEG_ONE));

    always_comb begin
        if (bus.nseg_i == '0)          nseg_clamp = NSEG_ONE;
        else if (bus.nseg_i > NSEG_MAX) nseg_clamp = NSEG_MAX;
        else                           nseg_clamp = bus.nseg_i;
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start_i) begin
                state_d = ST_LOAD;
                seg_d   = '0;
            end
            ST_LOAD: state_d = ST_TRIG;
            ST_TRIG: state_d = ST_RUN;
            default: if (run_end) begin
                if (!last_seg) begin
                    seg_d   = seg_q + SW'(1);
                    state_d = ST_LOAD;
                end else if (bus.loop_i) begin
                    seg_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        // Abort overrides every other transition and freezes the segment index.
        if (bus.stop_i) begin
            state_d = ST_IDLE;
            seg_d   = seg_q;
            done_d  = 1'b0;
        end
    end

    logic [CW-1:0] set_step_q, set_ofs_q, set_size_q;
    logic [15:0]   set_ncyc_q;
    logic          busy_q, set_rst_q, trig_q, done_q;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q     <= ST_IDLE;
            seg_q       <= '0;
            nseg_q      <= '0;
            dwell_q     <= '0;
            seg_dwell_q <= '0;
            set_step_q  <= '0;
            set_ofs_q   <= '0;
            set_size_q  <= '0;
            set_ncyc_q  <= '0;
            busy_q      <= 1'b0;
            set_rst_q   <= 1'b1;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            if (state_q == ST_IDLE && bus.start_i && !bus.stop_i) nseg_q <= nseg_clamp;
            if (state_q == ST_TRIG)     dwell_q <= (seg_dwell_q == '0) ? 32'd1 : seg_dwell_q;
            else if (state_q == ST_RUN) dwell_q <= dwell_q - 32'd1;
            // Config is captured on entry to LOAD so it is already stable during the LOAD cycle.
            if (state_d == ST_LOAD) begin
                set_step_q  <= tbl_q[seg_d].step;
                set_ofs_q   <= tbl_q[seg_d].ofs;
                set_size_q  <= tbl_q[seg_d].size;
                set_ncyc_q  <= tbl_q[seg_d].ncyc;
                seg_dwell_q <= tbl_q[seg_d].dwell;
            end
            busy_q    <= (state_d != ST_IDLE);
            set_rst_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            trig_q    <= (state_d == ST_TRIG);
            done_q    <= done_d;
        end
    end

    assign bus.cfg_rdata_o = cfg_rdata_q;
    assign bus.busy_o      = busy_q;
    assign bus.seg_o       = seg_q;
    assign bus.done_o      = done_q;
    assign bus.set_step_o  = set_step_q;
    assign bus.set_ofs_o   = set_ofs_q;
    assign bus.set_size_o  = set_size_q;
    assign bus.set_ncyc_o  = set_ncyc_q;
    assign bus.set_rst_o   = set_rst_q;
    assign bus.trig_sw_o   = trig_q;
endmodule

// File: tb/tb_asg_seg_sequencer.sv
// Bench for asg_seg_sequencer: expected trigger/done events are queued with their cycle numbers
// when a sequence is started; a negedge monitor pops and compares each event the DUT produces.
module tb_asg_seg_sequencer;
    localparam int RSZ  = 14;
    localparam int NSEG = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    asg_seg_sequencer_if #(.RSZ(RSZ), .NSEG(NSEG)) bus ();

    asg_seg_sequencer #(.RSZ(RSZ), .NSEG(NSEG)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    typedef struct {
        logic        done;
        int          cyc;
        int          seg;
        logic [29:0] step;
        logic [29:0] ofs;
        logic [29:0] size;
        logic [15:0] ncyc;
    } ev_t;

    ev_t exp_q [$];
    ev_t mon_e;

    logic [29:0] m_step  [NSEG];
    logic [29:0] m_ofs   [NSEG];
    logic [29:0] m_size  [NSEG];
    logic [15:0] m_ncyc  [NSEG];
    logic [31:0] m_dwell [NSEG];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.trig_sw_o || bus.done_o)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_event: got trig=%0b done=%0b seg=%0d at cyc %0d, required none",
                         bus.trig_sw_o, bus.done_o, bus.seg_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("ev%0d_done", mon_e.cyc), 64'(bus.done_o), 64'(mon_e.done));
                chk($sformatf("ev%0d_cyc", mon_e.cyc), 64'(cyc), 64'(mon_e.cyc));
                chk($sformatf("ev%0d_seg", mon_e.cyc), 64'(bus.seg_o), 64'(mon_e.seg));
                chk($sformatf("ev%0d_set_rst", mon_e.cyc), 64'(bus.set_rst_o), 64'(mon_e.done));
                if (!mon_e.done) begin
                    chk($sformatf("ev%0d_step", mon_e.cyc), 64'(bus.set_step_o), 64'(mon_e.step));
                    chk($sformatf("ev%0d_ofs", mon_e.cyc), 64'(bus.set_ofs_o), 64'(mon_e.ofs));
                    chk($sformatf("ev%0d_size", mon_e.cyc), 64'(bus.set_size_o), 64'(mon_e.size));
                    chk($sformatf("ev%0d_ncyc", mon_e.cyc), 64'(bus.set_ncyc_o), 64'(mon_e.ncyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSEG; i++) begin
            m_step[i] = '0; m_ofs[i] = '0; m_size[i] = '0; m_ncyc[i] = '0; m_dwell[i] = '0;
        end
    endtask

    task automatic wr(input int s, input int f, input logic [31:0] d);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = {3'(s), 3'(f)};
        bus.cfg_wdata_i = d;
        tick();
        bus.cfg_we_i = 1'b0;
        case (f)
            0: m_step[s]  = d[29:0];
            1: m_ofs[s]   = d[29:0];
            2: m_size[s]  = d[29:0];
            3: m_ncyc[s]  = d[15:0];
            4: m_dwell[s] = d;
            default: ;
        endcase
    endtask

    task automatic rd(input int s, input int f);
        logic [31:0] e;
        bus.cfg_addr_i = {3'(s), 3'(f)};
        tick();
        case (f)
            0: e = 32'(m_step[s]);
            1: e = 32'(m_ofs[s]);
            2: e = 32'(m_size[s]);
            3: e = 32'(m_ncyc[s]);
            4: e = m_dwell[s];
            default: e = '0;
        endcase
        chk($sformatf("rd_s%0d_f%0d", s, f), 64'(bus.cfg_rdata_o), 64'(e));
    endtask

    task automatic push_trig(input int c, input int s);
        ev_t e;
        e.done = 1'b0; e.cyc = c; e.seg = s;
        e.step = m_step[s]; e.ofs = m_ofs[s]; e.size = m_size[s]; e.ncyc = m_ncyc[s];
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c, input int s);
        ev_t e;
        e.done = 1'b1; e.cyc = c; e.seg = s;
        e.step = '0; e.ofs = '0; e.size = '0; e.ncyc = '0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int n, input logic lp);
        bus.nseg_i  = 4'(n);
        bus.loop_i  = lp;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    int k;

    initial begin
        bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0;
        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.nseg_i = '0; bus.loop_i = 1'b0;
        model_clear();

        // Reset values
        repeat (3) tick();
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_set_rst", 64'(bus.set_rst_o), 64'd1);
        chk("rst_trig", 64'(bus.trig_sw_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_seg", 64'(bus.seg_o), 64'd0);
        chk("rst_step", 64'(bus.set_step_o), 64'd0);
        chk("rst_rdata", 64'(bus.cfg_rdata_o), 64'd0);
        rst = 1'b0;
        tick();

        // Basic two-segment sequence
        wr(0, 0, 32'h0001_0000); wr(0, 1, 32'h0); wr(0, 2, 32'h3FFF_0000);
        wr(0, 3, 32'd2); wr(0, 4, 32'd5); wr(1, 4, 32'd3);
        k = cyc;
        push_trig(k + 2, 0); push_trig(k + 9, 1); push_done(k + 13, 1);
        pulse_start(2, 1'b0);
        chk("basic_load_busy", 64'(bus.busy_o), 64'd1);
        chk("basic_load_set_rst", 64'(bus.set_rst_o), 64'd1);
        chk("basic_load_step", 64'(bus.set_step_o), 64'h1_0000);
        wait_until(k + 3);
        chk("basic_run_set_rst", 64'(bus.set_rst_o), 64'd0);
        wait_until(k + 8);
        chk("basic_load1_seg", 64'(bus.seg_o), 64'd1);
        chk("basic_load1_set_rst", 64'(bus.set_rst_o), 64'd1);
        chk("basic_load1_size", 64'(bus.set_size_o), 64'd0);
        wait_until(k + 14);
        chk("basic_idle_busy", 64'(bus.busy_o), 64'd0);
        chk("basic_idle_done", 64'(bus.done_o), 64'd0);
        chk("basic_idle_seg", 64'(bus.seg_o), 64'd1);

        // Loop over three 3-cycle segments, then abort mid-RUN of seg1
        wr(0, 4, 32'd1); wr(1, 4, 32'd1); wr(2, 4, 32'd1);
        k = cyc;
        push_trig(k + 2, 0); push_trig(k + 5, 1); push_trig(k + 8, 2);
        push_trig(k + 11, 0); push_trig(k + 14, 1);
        pulse_start(3, 1'b1);
        wait_until(k + 15);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.loop_i = 1'b0;
        chk("stop_busy", 64'(bus.busy_o), 64'd0);
        chk("stop_set_rst", 64'(bus.set_rst_o), 64'd1);
        chk("stop_seg", 64'(bus.seg_o), 64'd1);
        wait_until(k + 20);

        // dwell 0 behaves as 1, with nseg 1 and nseg 0
        wr(0, 4, 32'd0);
        k = cyc; push_trig(k + 2, 0); push_done(k + 4, 0);
        pulse_start(1, 1'b0);
        wait_until(k + 6);
        k = cyc; push_trig(k + 2, 0); push_done(k + 4, 0);
        pulse_start(0, 1'b0);
        wait_until(k + 6);

        // nseg beyond the table depth clamps to NSEG
        k = cyc;
        for (int i = 0; i < NSEG; i++) push_trig(k + 2 + 3 * i, i);
        push_done(k + 25, NSEG - 1);
        pulse_start(NSEG + 3, 1'b0);
        wait_until(k + 27);

        // start during RUN is ignored
        wr(0, 4, 32'd4);
        k = cyc; push_trig(k + 2, 0); push_done(k + 7, 0);
        pulse_start(1, 1'b0);
        wait_until(k + 4);
        pulse_start(2, 1'b0);
        wait_until(k + 9);
        chk("start_in_run_idle", 64'(bus.busy_o), 64'd0);

        // start and stop together in IDLE stay in IDLE
        bus.start_i = 1'b1; bus.stop_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
        chk("start_stop_busy", 64'(bus.busy_o), 64'd0);
        chk("start_stop_set_rst", 64'(bus.set_rst_o), 64'd1);
        tick();
        chk("start_stop_busy2", 64'(bus.busy_o), 64'd0);

        // Rewrite seg0 while seg1 runs; the next loop pass picks it up
        wr(0, 4, 32'd1); wr(1, 4, 32'd6);
        k = cyc; push_trig(k + 2, 0); push_trig(k + 5, 1);
        pulse_start(2, 1'b1);
        wait_until(k + 7);
        wr(0, 1, 32'h1234);
        push_trig(k + 13, 0);
        wr(0, 6, 32'hDEAD_BEEF);
        wait_until(k + 12);
        chk("cfg_busy_load_ofs", 64'(bus.set_ofs_o), 64'h1234);
        chk("cfg_busy_load_seg", 64'(bus.seg_o), 64'd0);
        wait_until(k + 14);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.loop_i = 1'b0;
        chk("cfg_busy_stop", 64'(bus.busy_o), 64'd0);
        rd(0, 1); rd(0, 6); rd(0, 0); rd(0, 2); rd(0, 3); rd(0, 4); rd(1, 4); rd(7, 3); rd(0, 7);
        chk("rd_ofs_const", 64'(bus.cfg_rdata_o), 64'd0);

        // Asynchronous reset in the TRIG cycle
        wr(0, 4, 32'd3);
        k = cyc;
        pulse_start(1, 1'b0);
        wait_until(k + 2);
        chk("arst_pre_trig", 64'(bus.trig_sw_o), 64'd1);
        chk("arst_pre_set_rst", 64'(bus.set_rst_o), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_trig", 64'(bus.trig_sw_o), 64'd0);
        chk("arst_set_rst", 64'(bus.set_rst_o), 64'd1);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_step", 64'(bus.set_step_o), 64'd0);
        model_clear();
        tick(); tick();
        rst = 1'b0;
        tick();
        rd(0, 0); rd(0, 1); rd(1, 4);
        wr(0, 0, 32'h55); wr(0, 4, 32'd2);
        k = cyc; push_trig(k + 2, 0); push_done(k + 5, 0);
        pulse_start(1, 1'b0);
        wait_until(k + 7);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/asg_seg_sequencer.md
# asg_seg_sequencer

- Segment sequencer for one ASG channel.
- Holds a small table of waveform segments. Each segment has a step, offset, size, cycle count and dwell time.
- Plays the segments in order by reprogramming the channel's `set_*` inputs, pulsing `set_rst`, then issuing a software trigger.
- Sits between the ASG register bank and one `red_pitaya_asg_ch`. That channel must run with `trig_src_i = 1` (software).

## Interface

Parameters:
- `RSZ`, 14 — ASG buffer address width. Config words are `RSZ+16` bits.
- `NSEG`, 8 — table depth. Power of two, 2..16. `SW = $clog2(NSEG)`.

Ports:
- `dac_clk_i`  in  1  — DAC clock, single clock domain.
- `dac_rst_i`  in  1  — reset, asynchronous, active-high.
- `cfg_we_i`  in  1  — table write strobe.
- `cfg_addr_i`  in  SW+3  — address `{seg[SW-1:0], field[2:0]}`. Fields: 0 step, 1 ofs, 2 size, 3 ncyc, 4 dwell.
- `cfg_wdata_i`  in  32  — write data. Step/ofs/size use `[RSZ+15:0]`, ncyc uses `[15:0]`, dwell uses `[31:0]`.
- `cfg_rdata_o`  out  32  — registered readback of `cfg_addr_i`. Unused bits are 0.
- `start_i`  in  1  — start pulse.
- `stop_i`  in  1  — abort pulse.
- `nseg_i`  in  SW+1  — number of active segments. Latched on start.
- `loop_i`  in  1  — 1: after the last segment, restart at segment 0. Sampled at the end of the last segment.
- `busy_o`  out  1  — 1 while the state is not IDLE.
- `seg_o`  out  SW  — current segment index.
- `done_o`  out  1  — one-cycle pulse when a non-looping sequence completes.
- `set_step_o`, `set_ofs_o`, `set_size_o`  out  RSZ+16 each — to the channel.
- `set_ncyc_o`  out  16  — to the channel.
- `set_rst_o`  out  1  — to the channel's `set_rst_i`.
- `trig_sw_o`  out  1  — to the channel's `trig_sw_i`.

## Operation

- Table: NSEG × {step, ofs, size, ncyc, dwell}.
  - Write: the field is written on the edge where `cfg_we_i` is high.
  - Writes are allowed in any state.
  - A segment's entry is read only in LOAD, so a write takes effect the next time that segment is loaded.
  - Field codes 5..7: writes ignored, readback 0.
- FSM states: IDLE, LOAD, TRIG, RUN.
  - **IDLE**
    - `set_rst_o`=1; `trig_sw_o`=0; `busy_o`=0.
    - On `start_i`: latch `nseg_q` = clamp(`nseg_i`, 1, NSEG), i.e. 0→1 and >NSEG→NSEG. Set `seg_o`=0 and go to LOAD.
  - **LOAD**, 1 cycle
    - `set_*_o` ← table[`seg_o`].
    - `set_rst_o`=1.
    - Go to TRIG.
  - **TRIG**, 1 cycle
    - `set_rst_o`=0; `trig_sw_o`=1.
    - `dwell_cnt` ← max(dwell[`seg_o`], 1).
    - Go to RUN.
  - **RUN**
    - `set_rst_o`=0; `trig_sw_o`=0.
    - `dwell_cnt` decrements by 1 each cycle.
    - When `dwell_cnt`==1:
      - If `seg_o` < `nseg_q`-1: `seg_o`+1, go to LOAD.
      - Else if `loop_i`: `seg_o`=0, go to LOAD.
      - Else: go to IDLE and pulse `done_o`. `seg_o` holds its last value.
- `stop_i` in any state:
  - Next state is IDLE; no `done_o`; `seg_o` is held.
  - `stop_i` has priority over `start_i` and over RUN-end transitions.
- `start_i` outside IDLE is ignored.
- `set_*_o` hold their last loaded values in IDLE. The channel is parked via `set_rst_o`.
- Dwell counter is 32-bit unsigned. It never underflows because a dwell of 0 is treated as 1.

## Timing

- All outputs are registered and reflect the current state.
- Reset values: every output 0 except `set_rst_o`=1. State is IDLE, `seg_o`=0, table cleared to 0.
- `start_i` high at edge k:
  - LOAD is visible in cycle k+1.
  - `trig_sw_o`=1 in cycle k+2.
  - RUN lasts D = max(dwell, 1) cycles, cycles k+3 .. k+2+D.
  - The next segment's LOAD is at k+3+D.
- One segment occupies D+2 cycles.
- `done_o` is high in the first IDLE cycle.
- `set_*_o` are stable from LOAD through the end of RUN. When the channel samples the trigger, its config is already valid and `set_rst_i` is low.
- `cfg_rdata_o` latency: 1 cycle.
- Asynchronous reset mid-sequence forces the reset values immediately, including `set_rst_o`=1.

## Test plan

- **Basic sequence.** Program seg0 {step=0x10000, ofs=0, size=0x3FFF0000, ncyc=2, dwell=5} and seg1 {dwell=3}; `nseg_i`=2, `loop_i`=0; pulse start.
  - `trig_sw_o` pulses at k+2 and k+9.
  - `done_o` at k+13.
  - `seg_o` = 0 then 1.
  - `set_rst_o` is 1 only in IDLE/LOAD.
- **Loop then stop.** `nseg_i`=3, `loop_i`=1, all dwell=1. Pulse start.
  - `seg_o` cycles 0,1,2,0… with 3-cycle segments.
  - `stop_i` mid-RUN → IDLE next cycle, no `done_o`, `set_rst_o`=1.
- **Boundaries.**
  - dwell=0 behaves as dwell=1.
  - `nseg_i`=0 plays one segment.
  - `nseg_i`=NSEG+3 plays NSEG segments.
  - `start_i` during RUN is ignored.
  - `start_i`+`stop_i` together in IDLE → remains IDLE.
- **Config while busy.** While seg1 runs, rewrite seg0's ofs to 0x1234. On the next loop, seg0 LOAD drives `set_ofs_o`=0x1234.
  - Writes to field 6 are ignored.
  - Readback matches the written data one cycle after `cfg_addr_i` is applied.
- **Async reset.** Assert `dac_rst_i` mid-TRIG.
  - `trig_sw_o` drops immediately; `set_rst_o`=1; `busy_o`=0.
  - Table reads 0.
  - A new start works normally after release.
- **Integration with `red_pitaya_asg_ch`** (`trig_src_i`=1, 2 segments). The channel read pointer restarts at each segment's `set_ofs_o`, and the channel stops after that segment's ncyc cycles.
